// File: rtl/apb_master_ctrl_if.sv
// Bundle of the command, response and APB signals seen by apb_master_ctrl.
// The master modport is the controller's view; slave is the environment view.
interface apb_master_ctrl_if #(
   parameter int ID_NUM = 4,
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   localparam int STRB_W = DATA_W / 8;
   localparam int WR_W   = ID_NUM + ADDR_W + STRB_W + DATA_W;
   localparam int RD_W   = ID_NUM + ADDR_W;
   localparam int RSP_W  = 1 + ID_NUM + DATA_W + 1;

   // write command FIFO side: {id, addr, strb, data}
   logic              wr_vld_i;
   logic              wr_rdy_o;
   logic [WR_W-1:0]   wr_payload_i;
   // read command FIFO side: {id, addr}
   logic              rd_vld_i;
   logic              rd_rdy_o;
   logic [RD_W-1:0]   rd_payload_i;
   // response record: {is_wr, id, rdata, err}
   logic              rsp_vld_o;
   logic              rsp_rdy_i;
   logic [RSP_W-1:0]  rsp_payload_o;
   // APB bus
   logic              PSEL_o;
   logic              PENABLE_o;
   logic              PWRITE_o;
   logic [ADDR_W-1:0] PADDR_o;
   logic [DATA_W-1:0] PWDATA_o;
   logic [STRB_W-1:0] PSTRB_o;
   logic [DATA_W-1:0] PRDATA_i;
   logic              PREADY_i;
   logic              PSLVERR_i;

   modport master (
      input  wr_vld_i, wr_payload_i, rd_vld_i, rd_payload_i, rsp_rdy_i,
             PRDATA_i, PREADY_i, PSLVERR_i,
      output wr_rdy_o, rd_rdy_o, rsp_vld_o, rsp_payload_o,
             PSEL_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o, PSTRB_o
   );

   modport slave (
      output wr_vld_i, wr_payload_i, rd_vld_i, rd_payload_i, rsp_rdy_i,
             PRDATA_i, PREADY_i, PSLVERR_i,
      input  wr_rdy_o, rd_rdy_o, rsp_vld_o, rsp_payload_o,
             PSEL_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o, PSTRB_o
   );
endinterface

// File: rtl/apb_master_ctrl.sv
// APB-side sequencer of the AXI-to-APB bridge. Pops write/read commands with
// round-robin arbitration, runs one SETUP/ACCESS transfer at a time, enforces
// a PREADY timeout and hands a response record back to the AXI side.
module apb_master_ctrl #(
   parameter int ID_NUM      = 4,
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              PCLK_i,
   input  logic              PRESET_i,
   apb_master_ctrl_if.master bus,
   output logic              busy_o
);
   localparam int STRB_W = DATA_W / 8;
   // counter holds 0..TIMEOUT_CYC-1; a disabled timeout keeps a 1-bit stub
   localparam int CNT_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
   localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TO_LAST);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;

   state_e            state_q, state_d;
   logic              last_wr_q, last_wr_d;   // 1: last grant went to write
   logic              is_wr_q, is_wr_d;
   logic [ID_NUM-1:0] id_q, id_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [STRB_W-1:0] strb_q, strb_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [ID_NUM-1:0] wr_id, rd_id;
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic [STRB_W-1:0] wr_strb;
   logic [DATA_W-1:0] wr_data;
   logic              grant_pt, grant_wr, grant_rd, timeout;

   assign {wr_id, wr_addr, wr_strb, wr_data} = bus.wr_payload_i;
   assign {rd_id, rd_addr}                   = bus.rd_payload_i;

   // A grant may happen in IDLE or at the RESP handoff. Gating with reset keeps
   // the FIFOs from being popped while the command registers are held clear.
   assign grant_pt = !PRESET_i &&
                     ((state_q == S_IDLE) || (state_q == S_RESP && bus.rsp_rdy_i));
   // On a tie the side opposite the last grant wins.
   assign grant_wr = grant_pt && bus.wr_vld_i && (!bus.rd_vld_i || !last_wr_q);
   assign grant_rd = grant_pt && bus.rd_vld_i && !grant_wr;
   // Last ACCESS cycle allowed without PREADY; never fires when disabled.
   assign timeout  = (TIMEOUT_CYC > 0) && (cnt_q == TO_LAST_C);

   // Next-state, command capture and response capture.
   always_comb begin
      state_d   = state_q;
      last_wr_d = last_wr_q;
      is_wr_d   = is_wr_q;
      id_d      = id_q;
      addr_d    = addr_q;
      strb_d    = strb_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      cnt_d     = cnt_q;

      case (state_q)
         S_IDLE:   state_d = S_IDLE;
         S_SETUP:  state_d = S_ACCESS;
         S_ACCESS: begin
            cnt_d = cnt_q + 1'b1;
            // PREADY takes priority over a timeout landing in the same cycle
            if (bus.PREADY_i) begin
               err_d   = bus.PSLVERR_i;
               rdata_d = is_wr_q ? '0 : bus.PRDATA_i;
               state_d = S_RESP;
            end else if (timeout) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = S_RESP;
            end
         end
         S_RESP:   if (bus.rsp_rdy_i) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      // A grant overrides the IDLE/RESP outcome above and starts a new transfer.
      if (grant_wr) begin
         is_wr_d   = 1'b1;
         id_d      = wr_id;
         addr_d    = wr_addr;
         strb_d    = wr_strb;
         wdata_d   = wr_data;
         last_wr_d = 1'b1;
         cnt_d     = '0;
         state_d   = S_SETUP;
      end else if (grant_rd) begin
         // reads present zero strobes and data on the bus
         is_wr_d   = 1'b0;
         id_d      = rd_id;
         addr_d    = rd_addr;
         strb_d    = '0;
         wdata_d   = '0;
         last_wr_d = 1'b0;
         cnt_d     = '0;
         state_d   = S_SETUP;
      end
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge PCLK_i or posedge PRESET_i) begin
      if (PRESET_i) begin
         state_q   <= S_IDLE;
         last_wr_q <= 1'b0;
         is_wr_q   <= 1'b0;
         id_q      <= '0;
         addr_q    <= '0;
         strb_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         last_wr_q <= last_wr_d;
         is_wr_q   <= is_wr_d;
         id_q      <= id_d;
         addr_q    <= addr_d;
         strb_q    <= strb_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
      end
   end

   // Bus controls decode straight from state so reset drops them at once;
   // address/data come from the command registers and hold while idle.
   assign bus.PSEL_o        = (state_q == S_SETUP) || (state_q == S_ACCESS);
   assign bus.PENABLE_o     = (state_q == S_ACCESS);
   assign bus.PWRITE_o      = is_wr_q;
   assign bus.PADDR_o       = addr_q;
   assign bus.PWDATA_o      = wdata_q;
   assign bus.PSTRB_o       = strb_q;
   assign bus.wr_rdy_o      = grant_wr;
   assign bus.rd_rdy_o      = grant_rd;
   assign bus.rsp_vld_o     = (state_q == S_RESP);
   assign bus.rsp_payload_o = {is_wr_q, id_q, rdata_q, err_q};
   assign busy_o            = (state_q != S_IDLE);
endmodule
